// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the SRAM access sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mem_seq_state_e;

    localparam logic [31:0] SRAM_BASE_DEF   = 32'h0001_0000;
    localparam logic [31:0] SRAM_SIZE_DEF   = 32'h0001_0000;
    localparam int          TIMEOUT_CYC_DEF = 16;

    // Offset compare avoids overflow when the window ends at the top of the address space.
    function automatic logic in_sram_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] size);
        logic [31:0] offs;
        offs = addr - base;
        return (addr >= base) && (offs < size);
    endfunction

endpackage

// File: rtl/mem_seq_ctrl.sv
// Stalls the core around SRAM-window loads/stores, runs the req/ack handshake
// and aborts with a sticky error if the SRAM does not answer in time.
//
// state | meaning
// IDLE  | evaluate current instruction, pass non-SRAM accesses through
// WAIT  | request outstanding, PC stalled until ack or timeout
// ABORT | timed out: retire instruction without writeback, flag error
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE   = SRAM_BASE_DEF,
    parameter logic [31:0] SRAM_SIZE   = SRAM_SIZE_DEF,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic        i_mem_rden,
    input  logic        i_mem_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_sram_ack,
    input  logic        i_err_clr,
    output logic        o_pc_en,
    output logic        o_rd_wren_en,
    output logic        o_sram_req,
    output logic        o_sram_we,
    output logic        o_busy,
    output logic        o_err_pulse,
    output logic        o_err_flag,
    output logic [15:0] o_stall_cnt
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    mem_seq_state_e state;
    logic           we_q;
    logic [TW-1:0]  tcnt;
    logic           hit;
    logic           tmo;

    assign hit = i_insn_vld & (i_mem_rden | i_mem_wren)
               & in_sram_window(i_lsu_addr, SRAM_BASE, SRAM_SIZE);
    assign tmo = (tcnt == TLIM);

    // Stall/writeback gating must act in the same cycle as the decode.
    always_comb begin
        o_pc_en      = 1'b1;
        o_rd_wren_en = 1'b1;
        o_sram_req   = 1'b0;
        o_sram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    o_pc_en      = 1'b0;
                    o_rd_wren_en = 1'b0;
                end
            end
            WAIT: begin
                o_sram_req = 1'b1;
                o_sram_we  = we_q;
                if (i_sram_ack) begin
                    o_pc_en      = 1'b1;
                    o_rd_wren_en = ~we_q;
                end else begin
                    o_pc_en      = 1'b0;
                    o_rd_wren_en = 1'b0;
                end
            end
            ABORT: begin
                o_pc_en      = 1'b1;
                o_rd_wren_en = 1'b0;
            end
            default: begin
                o_pc_en      = 1'b1;
                o_rd_wren_en = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            tcnt        <= '0;
            o_err_flag  <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        we_q  <= i_mem_wren;
                        tcnt  <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_sram_ack) begin
                        state <= IDLE;
                    end else if (tmo) begin
                        state <= ABORT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase

            // A new abort outranks a simultaneous clear.
            if (state == ABORT) begin
                o_err_flag <= 1'b1;
            end else if (i_err_clr) begin
                o_err_flag <= 1'b0;
            end

            if (!o_pc_en && (o_stall_cnt != 16'hFFFF)) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_err_pulse = (state == ABORT);

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with a transaction-level reference model.
module tb_mem_seq_ctrl;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;
    localparam int          TMO  = 16;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_insn_vld = 1'b0;
    logic        i_mem_rden = 1'b0;
    logic        i_mem_wren = 1'b0;
    logic [31:0] i_lsu_addr = 32'h0;
    logic        i_sram_ack = 1'b0;
    logic        i_err_clr = 1'b0;
    logic        o_pc_en;
    logic        o_rd_wren_en;
    logic        o_sram_req;
    logic        o_sram_we;
    logic        o_busy;
    logic        o_err_pulse;
    logic        o_err_flag;
    logic [15:0] o_stall_cnt;

    always #5 i_clk = ~i_clk;

    mem_seq_ctrl #(
        .SRAM_BASE  (BASE),
        .SRAM_SIZE  (SIZE),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_insn_vld  (i_insn_vld),
        .i_mem_rden  (i_mem_rden),
        .i_mem_wren  (i_mem_wren),
        .i_lsu_addr  (i_lsu_addr),
        .i_sram_ack  (i_sram_ack),
        .i_err_clr   (i_err_clr),
        .o_pc_en     (o_pc_en),
        .o_rd_wren_en(o_rd_wren_en),
        .o_sram_req  (o_sram_req),
        .o_sram_we   (o_sram_we),
        .o_busy      (o_busy),
        .o_err_pulse (o_err_pulse),
        .o_err_flag  (o_err_flag),
        .o_stall_cnt (o_stall_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: is an access outstanding, how many WAIT cycles it has used, abort cycle pending.
    bit m_active = 0;
    bit m_abort  = 0;
    bit m_we     = 0;
    int m_waited = 0;
    bit m_flag   = 0;
    int m_stall  = 0;

    int obs_stall = 0;
    int obs_req   = 0;
    int obs_pulse = 0;
    int obs_we    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        longint unsigned a;
        bit hit;
        bit e_pc, e_rd, e_req, e_we, e_busy, e_pulse;
        if (i_reset) begin
            m_active = 0; m_abort = 0; m_we = 0; m_waited = 0;
            m_flag = 0; m_stall = 0;
        end
        a   = longint'(i_lsu_addr);
        hit = i_insn_vld && (i_mem_rden || i_mem_wren)
              && (a >= longint'(BASE)) && (a < longint'(BASE) + longint'(SIZE));
        e_req = 0; e_we = 0; e_pulse = 0;
        if (m_abort) begin
            e_pc = 1; e_rd = 0; e_busy = 1; e_pulse = 1;
        end else if (m_active) begin
            e_busy = 1; e_req = 1; e_we = m_we;
            e_pc = i_sram_ack; e_rd = i_sram_ack && !m_we;
        end else begin
            e_busy = 0; e_pc = !hit; e_rd = !hit;
        end
        chk("pc_en",      {31'b0, o_pc_en},      {31'b0, e_pc});
        chk("rd_wren_en", {31'b0, o_rd_wren_en}, {31'b0, e_rd});
        chk("sram_req",   {31'b0, o_sram_req},   {31'b0, e_req});
        chk("sram_we",    {31'b0, o_sram_we},    {31'b0, e_we});
        chk("busy",       {31'b0, o_busy},       {31'b0, e_busy});
        chk("err_pulse",  {31'b0, o_err_pulse},  {31'b0, e_pulse});
        chk("err_flag",   {31'b0, o_err_flag},   {31'b0, m_flag});
        chk("stall_cnt",  {16'b0, o_stall_cnt},  m_stall);
        if (!o_pc_en)    obs_stall++;
        if (o_sram_req)  obs_req++;
        if (o_err_pulse) obs_pulse++;
        if (o_sram_we)   obs_we++;
        if (!i_reset) begin
            if (!e_pc && m_stall < 65535) m_stall++;
            if (m_abort) m_flag = 1;
            else if (i_err_clr) m_flag = 0;
            if (m_abort) begin
                m_abort = 0;
            end else if (m_active) begin
                if (i_sram_ack) begin
                    m_active = 0;
                end else if (m_waited + 1 == TMO) begin
                    m_active = 0; m_abort = 1;
                end else begin
                    m_waited++;
                end
            end else if (hit) begin
                m_active = 1; m_waited = 0; m_we = i_mem_wren;
            end
        end
    endtask

    task automatic step(input logic vld, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic ack,
                        input logic clr, input logic rst);
        @(posedge i_clk);
        #1;
        i_insn_vld = vld; i_mem_rden = rd; i_mem_wren = wr;
        i_lsu_addr = addr; i_sram_ack = ack; i_err_clr = clr; i_reset = rst;
        @(negedge i_clk);
        model_check();
    endtask

    task automatic clr_obs();
        obs_stall = 0; obs_req = 0; obs_pulse = 0; obs_we = 0;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 32'h0, 0, 0, 1);
        step(0, 0, 0, 32'h0, 0, 0, 1);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("rst_stall", {16'b0, o_stall_cnt}, 0);
        chk("rst_flag",  {31'b0, o_err_flag},  0);
        chk("rst_busy",  {31'b0, o_busy},      0);
        clr_obs();
    endtask

    initial begin
        // 1: non-SRAM accesses pass straight through
        do_reset();
        step(1, 1, 0, 32'h0000_0100, 0, 0, 0);
        chk("t1_pc", {31'b0, o_pc_en}, 1);
        chk("t1_rd", {31'b0, o_rd_wren_en}, 1);
        step(1, 0, 1, 32'h0000_FFFC, 0, 0, 0);
        step(0, 1, 0, 32'h0001_0040, 0, 0, 0);
        step(1, 0, 0, 32'h0001_0040, 0, 0, 0);
        chk("t1_req_cnt", obs_req, 0);

        // 2: SRAM load, ack in WAIT cycle 3
        do_reset();
        step(1, 1, 0, 32'h0001_0040, 0, 0, 0);
        step(1, 1, 0, 32'h0001_0040, 0, 0, 0);
        step(1, 1, 0, 32'h0001_0040, 0, 0, 0);
        step(1, 1, 0, 32'h0001_0040, 1, 0, 0);
        chk("t2_ack_pc", {31'b0, o_pc_en}, 1);
        chk("t2_ack_rd", {31'b0, o_rd_wren_en}, 1);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t2_stall_cnt", {16'b0, o_stall_cnt}, 3);
        chk("t2_stall_obs", obs_stall, 3);
        chk("t2_req_obs", obs_req, 3);

        // 3: SRAM store acked on first WAIT cycle, then one-past-window store
        do_reset();
        step(1, 0, 1, 32'h0001_FFFC, 0, 0, 0);
        chk("t3_idle_rd", {31'b0, o_rd_wren_en}, 0);
        step(1, 0, 1, 32'h0001_FFFC, 1, 0, 0);
        chk("t3_we", {31'b0, o_sram_we}, 1);
        chk("t3_rd", {31'b0, o_rd_wren_en}, 0);
        chk("t3_pc", {31'b0, o_pc_en}, 1);
        step(1, 0, 1, 32'h0002_0000, 0, 0, 0);
        chk("t3_bound_pc", {31'b0, o_pc_en}, 1);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t3_stall_cnt", {16'b0, o_stall_cnt}, 1);
        chk("t3_req_obs", obs_req, 1);

        // 4: timeout
        do_reset();
        for (int i = 0; i < TMO + 2; i++) step(1, 1, 0, 32'h0001_0000, 0, 0, 0);
        chk("t4_abort_pulse", {31'b0, o_err_pulse}, 1);
        chk("t4_abort_rd", {31'b0, o_rd_wren_en}, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t4_flag", {31'b0, o_err_flag}, 1);
        chk("t4_stall_cnt", {16'b0, o_stall_cnt}, 17);
        chk("t4_pulse_obs", obs_pulse, 1);
        chk("t4_req_obs", obs_req, 16);

        // 5: ack at the limit, then clear colliding with a new abort
        do_reset();
        for (int i = 0; i < TMO + 1; i++) step(1, 1, 0, 32'h0001_8000, (i == TMO), 0, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t5_flag", {31'b0, o_err_flag}, 0);
        chk("t5_pulse_obs", obs_pulse, 0);
        chk("t5_stall_cnt", {16'b0, o_stall_cnt}, 16);
        for (int i = 0; i < TMO + 2; i++) step(1, 1, 0, 32'h0001_8000, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t5_set_wins", {31'b0, o_err_flag}, 1);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t5_cleared", {31'b0, o_err_flag}, 0);

        // 6: reset mid-WAIT, stray ack afterwards
        do_reset();
        step(1, 1, 0, 32'h0001_0010, 0, 0, 0);
        step(1, 1, 0, 32'h0001_0010, 0, 0, 0);
        step(1, 1, 0, 32'h0001_0010, 0, 0, 0);
        chk("t6_pre_req", {31'b0, o_sram_req}, 1);
        step(1, 1, 0, 32'h0001_0010, 0, 0, 1);
        chk("t6_rst_req", {31'b0, o_sram_req}, 0);
        chk("t6_rst_busy", {31'b0, o_busy}, 0);
        step(0, 0, 0, 32'h0, 1, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        chk("t6_stray_busy", {31'b0, o_busy}, 0);
        chk("t6_stray_req", {31'b0, o_sram_req}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
